// File: rtl/pcm_frame_fifo.sv
// pcm_frame_fifo: stores parallel PCM frames and serialises them one channel per ready/valid transfer
module pcm_frame_fifo #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                      CLKDIVF0,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [CHANNELS*WIDTH-1:0] PCM_IN,
  output logic [WIDTH-1:0]          OUT_DATA,
  output logic [CW-1:0]             OUT_CH,
  output logic                      OUT_SOF,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [LW-1:0]             LEVEL,
  output logic                      FULL,
  output logic                      EMPTY,
  output logic [7:0]                OVF_CNT
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q;
  logic [CHANNELS*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] ch_q;
  logic [7:0] ovf_q;
  logic xfer, last, pop, push, drop;
  assign OUT_VALID = state_q == STREAM;
  assign xfer = OUT_VALID && OUT_READY;
  assign last = ch_q == CW'(CHANNELS - 1);
  assign pop = xfer && last;
  assign FULL = level_q == LW'(DEPTH);
  assign EMPTY = level_q == '0;
  // a pop on the same edge frees the slot, so a full FIFO still accepts
  assign push = EN && (!FULL || pop);
  assign drop = EN && FULL && !pop;
  assign level_d = level_q + LW'(push) - LW'(pop);
  assign OUT_DATA = OUT_VALID ? mem_q[rd_q][ch_q*WIDTH +: WIDTH] : '0;
  assign OUT_CH = ch_q;
  assign OUT_SOF = OUT_VALID && ch_q == '0;
  assign LEVEL = level_q;
  assign OVF_CNT = ovf_q;
  always_ff @(posedge CLKDIVF0)
    if (push) mem_q[wr_q] <= PCM_IN;
  always_ff @(posedge CLKDIVF0 or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ch_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      ovf_q <= '0;
    end else begin
      wr_q <= push ? wr_q + AW'(1) : wr_q;
      rd_q <= pop ? rd_q + AW'(1) : rd_q;
      level_q <= level_d;
      ovf_q <= (drop && ovf_q != 8'hff) ? ovf_q + 8'd1 : ovf_q;
      case (state_q)
        IDLE: state_q <= level_q != '0 ? STREAM : IDLE;
        STREAM: begin
          ch_q <= xfer ? (last ? '0 : ch_q + CW'(1)) : ch_q;
          state_q <= (pop && level_d == '0) ? IDLE : STREAM;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
